// File: rtl/csr_if.sv
// csr_if: commit-stage to CSR unit bundle. The commit stage (master) drives
// the decoded system flags and operands; the CSR unit (slave) returns the
// old CSR value, the trap flag and the fetch redirect.
interface csr_if;
  logic        valid;
  logic        csr_write;
  logic        is_ecall;
  logic        is_mret;
  logic        illegal_instr;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] csr_src;
  logic        retire;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap;

  modport master (
    output valid, csr_write, is_ecall, is_mret, illegal_instr,
    output instr, pc, csr_src, retire,
    input  csr_rdata, redirect, redirect_pc, trap
  );

  modport slave (
    input  valid, csr_write, is_ecall, is_mret, illegal_instr,
    input  instr, pc, csr_src, retire,
    output csr_rdata, redirect, redirect_pc, trap
  );
endinterface

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and trap sequencer at the commit stage.
// Performs CSRRW/S/C(I), takes ECALL / illegal-instruction traps, executes
// MRET and drives the fetch redirect. Optional feature macro
// CSR_COUNTERS_EN adds the 64-bit mcycle/minstret counters; without it the
// counter addresses are unimplemented and trap as illegal.
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input logic   clk,
  input logic   rst_n,
  csr_if.slave  bus
);

  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_next;

  logic        mie, mpie;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
  logic [63:0] mcycle_next, minstret_next;
`endif

  logic [11:0] addr;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic        active, wr_en, hit, read_only, csr_ill, mret_take, csr_we;
  logic        trap_take;
  logic [31:0] rdata, wdata;

  assign addr   = bus.instr[31:20];
  assign funct3 = bus.instr[14:12];
  assign rs1    = bus.instr[19:15];

  // The squashed instruction sitting in commit during FLUSH is ignored.
  assign active = rst_n && bus.valid && (state == RUN);

  // Set/clear with rs1/uimm == 0 is a pure read; funct3 x00 never writes.
  assign wr_en     = (funct3[1:0] == 2'b01) || (funct3[1] && (rs1 != 5'd0));
  assign read_only = (addr[11:10] == 2'b11) || (addr == 12'h301);

  // Read mux over the implemented CSRs; hit flags an implemented address.
  always_comb begin
    rdata = 32'd0;
    hit   = 1'b1;
    case (addr)
      12'h300: rdata = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
      12'h301: rdata = 32'h4000_0100;
      12'h305: rdata = mtvec;
      12'h340: rdata = mscratch;
      12'h341: rdata = mepc;
      12'h342: rdata = mcause;
      12'h343: rdata = mtval;
      12'hF14: rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
      12'hB00: rdata = mcycle[31:0];
      12'hB80: rdata = mcycle[63:32];
      12'hB02: rdata = minstret[31:0];
      12'hB82: rdata = minstret[63:32];
`endif
      default: hit = 1'b0;
    endcase
  end

  // Read-modify-write value from the old CSR contents and the ALU operand.
  always_comb begin
    case (funct3[1:0])
      2'b10:   wdata = rdata | bus.csr_src;
      2'b11:   wdata = rdata & ~bus.csr_src;
      default: wdata = bus.csr_src;
    endcase
  end

  assign csr_ill   = bus.csr_write && (!hit || (wr_en && read_only));
  assign trap_take = active && (bus.illegal_instr || bus.is_ecall || csr_ill);
  assign mret_take = active && bus.is_mret && !trap_take;
  assign csr_we    = active && bus.csr_write && wr_en && !trap_take;

  assign bus.csr_rdata   = rdata;
  assign bus.trap        = trap_take;
  assign bus.redirect    = trap_take || mret_take;
  assign bus.redirect_pc = trap_take ? mtvec : (mret_take ? mepc : 32'd0);

  // Trap sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // One FLUSH cycle follows every redirect.
  always_comb begin
    state_next = RUN;
    if (state == RUN && bus.redirect) state_next = FLUSH;
  end

  // Architectural CSR updates: trap entry, MRET, then explicit writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= {MTVEC_RESET[31:2], 2'b00};
      mscratch <= 32'd0;
      mepc     <= 32'd0;
      mcause   <= 32'd0;
      mtval    <= 32'd0;
    end else if (trap_take) begin
      mepc   <= bus.pc;
      mcause <= (bus.illegal_instr || csr_ill) ? 32'd2 : 32'd11;
      mtval  <= (bus.illegal_instr || csr_ill) ? bus.instr : 32'd0;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (mret_take) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (csr_we) begin
      case (addr)
        12'h300: begin
          mie  <= wdata[3];
          mpie <= wdata[7];
        end
        12'h305: mtvec    <= {wdata[31:2], 2'b00};
        12'h340: mscratch <= wdata;
        12'h341: mepc     <= {wdata[31:2], 2'b00};
        12'h342: mcause   <= wdata;
        12'h343: mtval    <= wdata;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // Counter next values; a write to a half replaces that half's increment.
  always_comb begin
    mcycle_next   = mcycle + 64'd1;
    minstret_next = minstret + ((active && bus.retire && !trap_take) ? 64'd1 : 64'd0);
    if (csr_we) begin
      case (addr)
        12'hB00: mcycle_next[31:0]    = wdata;
        12'hB80: mcycle_next[63:32]   = wdata;
        12'hB02: minstret_next[31:0]  = wdata;
        12'hB82: minstret_next[63:32] = wdata;
        default: ;
      endcase
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= 64'd0;
      minstret <= 64'd0;
    end else begin
      mcycle   <= mcycle_next;
      minstret <= minstret_next;
    end
  end
`endif

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed-vector bench for csr_unit with hand-computed
// expectations. Instantiated with MTVEC_RESET = 0x83 (reads back as 0x80)
// and HART_ID = 3.
module tb_csr_unit;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  csr_if bus ();

  csr_unit #(.MTVEC_RESET(32'h0000_0083), .HART_ID(32'd3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [11:0] a, input logic [4:0] r, input logic [2:0] f3);
    return {a, r, f3, 5'd1, 7'h73};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid = 0; bus.csr_write = 0; bus.is_ecall = 0; bus.is_mret = 0;
    bus.illegal_instr = 0; bus.instr = 0; bus.pc = 0; bus.csr_src = 0; bus.retire = 0;
  endtask

  task automatic drive_csr(input logic [11:0] a, input logic [4:0] r, input logic [2:0] f3,
                           input logic [31:0] src);
    idle();
    bus.valid = 1; bus.csr_write = 1; bus.instr = mk(a, r, f3); bus.csr_src = src; bus.retire = 1;
    #1;
  endtask

  // Read via CSRRS rs1=x0 and check the returned value.
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    drive_csr(a, 5'd0, 3'b010, 32'd0);
    chk(tag, bus.csr_rdata, exp);
    tick();
    idle();
  endtask

  task automatic wr(input logic [11:0] a, input logic [4:0] r, input logic [2:0] f3,
                    input logic [31:0] src);
    drive_csr(a, r, f3, src);
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    bus.valid = 1; bus.is_ecall = 1; bus.instr = mk(12'h301, 5'd0, 3'b010);
    #12;
    chk("rst_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("rst_trap", {31'd0, bus.trap}, 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_rdata_misa", bus.csr_rdata, 32'h4000_0100);
    idle();
    @(negedge clk);
    rst_n = 1;
    tick();

    rd("mtvec_reset", 12'h305, 32'h0000_0080);
    rd("misa", 12'h301, 32'h4000_0100);
    rd("mhartid", 12'hF14, 32'd3);
    rd("mstatus_reset", 12'h300, 32'h0000_1800);
    rd("mscratch_reset", 12'h340, 32'd0);

    // CSRRW returns old value, then back-to-back read sees the new one.
    drive_csr(12'h340, 5'd1, 3'b001, 32'hDEAD_BEEF);
    chk("csrrw_old", bus.csr_rdata, 32'd0);
    tick();
    // CSRRS with rs1=x0 but a nonzero operand must not write.
    drive_csr(12'h340, 5'd0, 3'b010, 32'hFFFF_FFFF);
    chk("csrrs_x0_read", bus.csr_rdata, 32'hDEAD_BEEF);
    tick(); idle();
    rd("csrrs_x0_nowrite", 12'h340, 32'hDEAD_BEEF);
    wr(12'h340, 5'd2, 3'b011, 32'hFFFF_0000);
    rd("csrrc", 12'h340, 32'h0000_BEEF);
    wr(12'h340, 5'd16, 3'b110, 32'h0001_0000);
    rd("csrrsi", 12'h340, 32'h0001_BEEF);
    wr(12'h305, 5'd1, 3'b001, 32'h0000_0203);
    rd("mtvec_align", 12'h305, 32'h0000_0200);
    wr(12'h300, 5'd8, 3'b110, 32'h0000_0008);
    rd("mstatus_mie", 12'h300, 32'h0000_1808);

    // ECALL, then a CSR write during FLUSH that must be ignored.
    idle();
    bus.valid = 1; bus.is_ecall = 1; bus.pc = 32'h100; bus.instr = 32'h0000_0073;
    #1;
    chk("ecall_trap", {31'd0, bus.trap}, 32'd1);
    chk("ecall_redirect", {31'd0, bus.redirect}, 32'd1);
    chk("ecall_redirect_pc", bus.redirect_pc, 32'h200);
    tick();
    drive_csr(12'h340, 5'd1, 3'b001, 32'h1234_5678);
    bus.is_ecall = 1;
    #1;
    chk("flush_redirect", {31'd0, bus.redirect}, 32'd0);
    chk("flush_trap", {31'd0, bus.trap}, 32'd0);
    tick(); idle();
    rd("flush_ignored", 12'h340, 32'h0001_BEEF);
    rd("ecall_mepc", 12'h341, 32'h100);
    rd("ecall_mcause", 12'h342, 32'd11);
    rd("ecall_mtval", 12'h343, 32'd0);
    rd("ecall_mstatus", 12'h300, 32'h0000_1880);

    // Write to read-only mhartid traps as illegal.
    idle();
    bus.valid = 1; bus.csr_write = 1; bus.instr = 32'hF140_1073; bus.pc = 32'h0000_0300;
    #1;
    chk("ro_trap", {31'd0, bus.trap}, 32'd1);
    tick(); idle(); tick();
    rd("ro_mcause", 12'h342, 32'd2);
    rd("ro_mtval", 12'h343, 32'hF140_1073);
    rd("ro_mhartid", 12'hF14, 32'd3);
    rd("ro_mstatus", 12'h300, 32'h0000_1800);

    // MRET: mepc aligned on write, MPIE set beforehand.
    wr(12'h341, 5'd1, 3'b001, 32'h0000_0107);
    rd("mepc_align", 12'h341, 32'h104);
    wr(12'h300, 5'd1, 3'b110, 32'h0000_0080);
    idle();
    bus.valid = 1; bus.is_mret = 1; bus.instr = 32'h3020_0073;
    #1;
    chk("mret_redirect", {31'd0, bus.redirect}, 32'd1);
    chk("mret_pc", bus.redirect_pc, 32'h104);
    chk("mret_notrap", {31'd0, bus.trap}, 32'd0);
    tick(); idle(); tick();
    rd("mret_mstatus", 12'h300, 32'h0000_1888);

    // Illegal + ECALL + CSR write together: illegal wins, no CSR write.
    idle();
    bus.valid = 1; bus.illegal_instr = 1; bus.is_ecall = 1; bus.csr_write = 1;
    bus.instr = 32'h3400_90F3; bus.csr_src = 32'h0000_AAAA; bus.pc = 32'h40;
    #1;
    chk("prio_trap", {31'd0, bus.trap}, 32'd1);
    tick(); idle(); tick();
    rd("prio_mcause", 12'h342, 32'd2);
    rd("prio_mtval", 12'h343, 32'h3400_90F3);
    rd("prio_mepc", 12'h341, 32'h40);
    rd("prio_mscratch", 12'h340, 32'h0001_BEEF);
    rd("prio_mstatus", 12'h300, 32'h0000_1880);

`ifdef CSR_COUNTERS_EN
    wr(12'hB00, 5'd1, 3'b001, 32'hFFFF_FFFF);
    tick();
    rd("mcycleh_carry", 12'hB80, 32'd1);
`else
    drive_csr(12'hB00, 5'd0, 3'b010, 32'd0);
    chk("nocnt_trap", {31'd0, bus.trap}, 32'd1);
    tick(); idle(); tick();
    rd("nocnt_mcause", 12'h342, 32'd2);
`endif

    // Asynchronous reset mid-run clears state immediately.
    drive_csr(12'h340, 5'd0, 3'b010, 32'd0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("async_rst_mscratch", bus.csr_rdata, 32'd0);
    idle();
    #20;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
